// File: rtl/cp0_exception_unit_if.sv
// rtl/cp0_exception_unit_if.sv - CP0 register bus and fetch redirect handshake
//
// Purpose: bundles the MTC0/MFC0 register access bus and the flush /
// PC-redirect handshake between the CP0 exception unit and the pipeline.
//
// Signals:
//   mtc0_we        MTC0 write strobe
//   mtc0_addr[5]   CP0 register number for writes (12 STATUS, 13 CAUSE, 14 EPC)
//   mtc0_wdata[32] MTC0 write data
//   mfc0_addr[5]   CP0 register number for reads
//   mfc0_rdata[32] combinational read data, unmapped numbers read 0
//   redirect_ready fetch accepts the redirect this cycle
//   redirect_valid redirect request
//   redirect_pc    redirect target, stable while redirect_valid=1
//   flush          kill IF/ID/EXE, equals redirect_valid
//
// Modports:
//   slave  - CP0 exception unit side
//   master - pipeline / fetch side
interface cp0_exception_unit_if;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_rdata;
  logic        redirect_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;

  modport slave (
    input  mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr, redirect_ready,
    output mfc0_rdata, redirect_valid, redirect_pc, flush
  );

  modport master (
    output mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr, redirect_ready,
    input  mfc0_rdata, redirect_valid, redirect_pc, flush
  );
endinterface

// File: rtl/cp0_exception_unit.sv
// rtl/cp0_exception_unit.sv - CP0 STATUS/CAUSE/EPC owner, trap/ERET decision and fetch redirect
//
// Purpose: samples pending exceptions, ERET and interrupts in the RUN state,
// updates STATUS, CAUSE and EPC, and holds a flush / PC-redirect request
// towards fetch until it is accepted.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   irq[6]               external interrupt levels -> CAUSE.IP[7:2]
//   id_syscall           SYSCALL in ID
//   id_unknown           reserved / unknown opcode in ID
//   id_eret              ERET in ID
//   exe_overflow         arithmetic overflow in EXE
//   id_pc[32], exe_pc[32] PCs of the ID and EXE instructions
//   bus                  cp0_exception_unit_if.slave (MTC0/MFC0, redirect handshake)
//   status_out, cause_out, epc_out [32] current register values
//
// Configuration macro: CP0_IRQ_SYNC_EN
//   defined   - irq passes a two-flop synchronizer before CAUSE.IP[7:2]
//   undefined - irq is synchronous to clk and feeds CAUSE.IP[7:2] directly
module cp0_exception_unit #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [5:0]                   irq,
  input  logic                         id_syscall,
  input  logic                         id_unknown,
  input  logic                         id_eret,
  input  logic                         exe_overflow,
  input  logic [31:0]                  id_pc,
  input  logic [31:0]                  exe_pc,
  cp0_exception_unit_if.slave          bus,
  output logic [31:0]                  status_out,
  output logic [31:0]                  cause_out,
  output logic [31:0]                  epc_out
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_TRAP = 2'd1,
    S_RET  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        ie_q, ie_d;
  logic        exl_q, exl_d;
  logic [7:0]  im_q, im_d;
  logic [4:0]  exc_q, exc_d;
  logic [1:0]  swip_q, swip_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] rpc_q, rpc_d;
  logic        rvalid_q, rvalid_d;

  // Hardware interrupt lines as seen by CAUSE.IP[7:2].
  logic [5:0]  hw_ip;

`ifdef CP0_IRQ_SYNC_EN
  logic [5:0]  sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
    end
  end

  assign hw_ip = sync2_q;
`else
  assign hw_ip = irq;
`endif

  logic [7:0]  ip;
  logic        int_take;
  logic        trap;
  logic [4:0]  trap_code;
  logic [31:0] trap_pc;

  assign ip       = {hw_ip, swip_q};
  // EXL masks interrupts, so a handler is never interrupted by a new IRQ.
  assign int_take = ie_q & ~exl_q & (|(ip & im_q));

  always_comb begin
    state_d   = state_q;
    ie_d      = ie_q;
    exl_d     = exl_q;
    im_d      = im_q;
    exc_d     = exc_q;
    swip_d    = swip_q;
    epc_d     = epc_q;
    rpc_d     = rpc_q;
    rvalid_d  = rvalid_q;
    trap      = 1'b0;
    trap_code = EXC_INT;
    trap_pc   = id_pc;

    case (state_q)
      S_RUN: begin
        if (exe_overflow) begin
          trap      = 1'b1;
          trap_code = EXC_OV;
          trap_pc   = exe_pc;
        end else if (id_syscall) begin
          trap      = 1'b1;
          trap_code = EXC_SYS;
        end else if (id_unknown) begin
          trap      = 1'b1;
          trap_code = EXC_RI;
        end else if (id_eret) begin
          exl_d    = 1'b0;
          rpc_d    = epc_q;
          rvalid_d = 1'b1;
          state_d  = S_RET;
        end else if (int_take) begin
          trap      = 1'b1;
          trap_code = EXC_INT;
        end else if (bus.mtc0_we) begin
          // Any event above flushes the MTC0 instruction, so only an
          // event-free cycle commits the write.
          case (bus.mtc0_addr)
            REG_STATUS: begin
              ie_d  = bus.mtc0_wdata[0];
              exl_d = bus.mtc0_wdata[1];
              im_d  = bus.mtc0_wdata[15:8];
            end
            REG_CAUSE: swip_d = bus.mtc0_wdata[9:8];
            REG_EPC:   epc_d  = bus.mtc0_wdata;
            default:   ;
          endcase
        end

        if (trap) begin
          exl_d = 1'b1;
          exc_d = trap_code;
          // A nested exception keeps the EPC of the original one.
          if (!exl_q) begin
            epc_d = trap_pc;
          end
          rpc_d    = EXC_VECTOR;
          rvalid_d = 1'b1;
          state_d  = S_TRAP;
        end
      end

      default: begin
        // TRAP / RET: hold the request, ignore new events.
        if (bus.redirect_ready) begin
          rvalid_d = 1'b0;
          state_d  = S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      ie_q     <= 1'b0;
      exl_q    <= 1'b0;
      im_q     <= '0;
      exc_q    <= '0;
      swip_q   <= '0;
      epc_q    <= '0;
      rpc_q    <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ie_q     <= ie_d;
      exl_q    <= exl_d;
      im_q     <= im_d;
      exc_q    <= exc_d;
      swip_q   <= swip_d;
      epc_q    <= epc_d;
      rpc_q    <= rpc_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign status_out = {16'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_out  = {16'b0, ip, 1'b0, exc_q, 2'b0};
  assign epc_out    = epc_q;

  always_comb begin
    case (bus.mfc0_addr)
      REG_STATUS: bus.mfc0_rdata = status_out;
      REG_CAUSE:  bus.mfc0_rdata = cause_out;
      REG_EPC:    bus.mfc0_rdata = epc_q;
      default:    bus.mfc0_rdata = 32'b0;
    endcase
  end

  assign bus.redirect_valid = rvalid_q;
  assign bus.flush          = rvalid_q;
  assign bus.redirect_pc    = rpc_q;

  // STATUS/CAUSE only implement a few bits of the write data.
  logic unused_wdata;
  assign unused_wdata = ^{bus.mtc0_wdata[31:16], bus.mtc0_wdata[7:2]};

endmodule

// File: tb/tb_cp0_exception_unit.sv
// tb/tb_cp0_exception_unit.sv - randomized self-checking bench for cp0_exception_unit
module tb_cp0_exception_unit;

  logic        clk;
  logic        rst_n;
  logic [5:0]  irq;
  logic        id_syscall, id_unknown, id_eret, exe_overflow;
  logic [31:0] id_pc, exe_pc;
  logic [31:0] status_out, cause_out, epc_out;

  cp0_exception_unit_if bus();

  cp0_exception_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq          (irq),
    .id_syscall   (id_syscall),
    .id_unknown   (id_unknown),
    .id_eret      (id_eret),
    .exe_overflow (exe_overflow),
    .id_pc        (id_pc),
    .exe_pc       (exe_pc),
    .bus          (bus),
    .status_out   (status_out),
    .cause_out    (cause_out),
    .epc_out      (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_ie, m_exl, m_busy;
  bit [7:0]  m_im;
  bit [4:0]  m_code;
  bit [1:0]  m_swip;
  bit [31:0] m_epc, m_rpc;
  bit [5:0]  m_s1, m_s2;

  function automatic bit [5:0] m_hwip();
`ifdef CP0_IRQ_SYNC_EN
    return m_s2;
`else
    return irq;
`endif
  endfunction

  function automatic bit [31:0] m_status();
    return {16'b0, m_im, 6'b0, m_exl, m_ie};
  endfunction

  function automatic bit [31:0] m_cause();
    return {16'b0, m_hwip(), m_swip, 1'b0, m_code, 2'b0};
  endfunction

  task automatic m_trap(input bit [4:0] code, input bit [31:0] pc);
    if (!m_exl) m_epc = pc;
    m_exl  = 1'b1;
    m_code = code;
    m_rpc  = 32'h4;
    m_busy = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ie = 0; m_exl = 0; m_busy = 0; m_im = 0; m_code = 0;
      m_swip = 0; m_epc = 0; m_rpc = 0; m_s1 = 0; m_s2 = 0;
    end else begin
      if (m_busy) begin
        if (bus.redirect_ready) m_busy = 1'b0;
      end else if (exe_overflow) m_trap(5'd12, exe_pc);
      else if (id_syscall)      m_trap(5'd8, id_pc);
      else if (id_unknown)      m_trap(5'd10, id_pc);
      else if (id_eret) begin
        m_exl  = 1'b0;
        m_rpc  = m_epc;
        m_busy = 1'b1;
      end else if (m_ie && !m_exl && (({m_hwip(), m_swip} & m_im) != 0))
        m_trap(5'd0, id_pc);
      else if (bus.mtc0_we) begin
        if (bus.mtc0_addr == 5'd12) begin
          m_ie  = bus.mtc0_wdata[0];
          m_exl = bus.mtc0_wdata[1];
          m_im  = bus.mtc0_wdata[15:8];
        end else if (bus.mtc0_addr == 5'd13) m_swip = bus.mtc0_wdata[9:8];
        else if (bus.mtc0_addr == 5'd14)     m_epc  = bus.mtc0_wdata;
      end
      m_s2 = m_s1;
      m_s1 = irq;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] exp_rd;
      chk("status", status_out, m_status());
      chk("cause", cause_out, m_cause());
      chk("epc", epc_out, m_epc);
      chk("redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, m_busy});
      chk("flush", {31'b0, bus.flush}, {31'b0, m_busy});
      if (m_busy) chk("redirect_pc", bus.redirect_pc, m_rpc);
      case (bus.mfc0_addr)
        5'd12:   exp_rd = m_status();
        5'd13:   exp_rd = m_cause();
        5'd14:   exp_rd = m_epc;
        default: exp_rd = 32'b0;
      endcase
      chk("mfc0_rdata", bus.mfc0_rdata, exp_rd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    id_syscall = 0; id_unknown = 0; id_eret = 0; exe_overflow = 0;
    bus.mtc0_we = 0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.redirect_valid && n < budget) begin
      tick();
      n++;
    end
    if (!bus.redirect_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: redirect_valid stayed 0 for %0d cycles", budget);
    end
  endtask

  initial begin
    logic [4:0] rd_addrs [4];
    rd_addrs[0] = 5'd12; rd_addrs[1] = 5'd13; rd_addrs[2] = 5'd14; rd_addrs[3] = 5'd5;

    rst_n = 1'b0;
    irq = 0; id_pc = 0; exe_pc = 0;
    clear_events();
    bus.mtc0_addr = 0; bus.mtc0_wdata = 0; bus.mfc0_addr = 5'd5;
    bus.redirect_ready = 1'b0;
    cmp_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset values
    chk("rst_status", status_out, 32'h0);
    chk("rst_cause", cause_out, 32'h0);
    chk("rst_epc", epc_out, 32'h0);
    chk("rst_valid", {31'b0, bus.redirect_valid}, 32'h0);
    chk("rst_flush", {31'b0, bus.flush}, 32'h0);
    chk("rst_rpc", bus.redirect_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.mfc0_addr = rd_addrs[i];
      #1;
      chk("rst_mfc0", bus.mfc0_rdata, 32'h0);
    end
    bus.mfc0_addr = 5'd5;

    // Interrupt trap
    bus.mtc0_we = 1; bus.mtc0_addr = 5'd12; bus.mtc0_wdata = 32'h0000_0401;
    tick();
    clear_events();
    chk("mtc0_status", status_out, 32'h0000_0401);
    irq = 6'b000001; id_pc = 32'h40;
    wait_valid(10);
    chk("int_rpc", bus.redirect_pc, 32'h4);
    chk("int_epc", epc_out, 32'h40);
    chk("int_code", {27'b0, cause_out[6:2]}, 32'd0);
    chk("int_status", status_out, 32'h0000_0403);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("int_hold", {31'b0, bus.flush}, 32'd1);
    end
    bus.redirect_ready = 1;
    tick();
    bus.redirect_ready = 0;
    chk("int_drop", {31'b0, bus.redirect_valid}, 32'd0);

    // Nested syscall with EXL=1: EPC kept, interrupt stays masked
    id_syscall = 1; id_pc = 32'h90;
    tick();
    clear_events();
    chk("nest_valid", {31'b0, bus.redirect_valid}, 32'd1);
    chk("nest_code", {27'b0, cause_out[6:2]}, 32'd8);
    chk("nest_epc", epc_out, 32'h40);
    bus.redirect_ready = 1;
    tick();
    bus.redirect_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("masked_int", {31'b0, bus.redirect_valid}, 32'd0);
    end

    // ERET
    irq = 0;
    repeat (4) tick();
    id_eret = 1; bus.redirect_ready = 1;
    tick();
    clear_events();
    chk("eret_valid", {31'b0, bus.redirect_valid}, 32'd1);
    chk("eret_rpc", bus.redirect_pc, 32'h40);
    chk("eret_status", status_out, 32'h0000_0401);
    tick();
    chk("eret_1cyc", {31'b0, bus.redirect_valid}, 32'd0);

    // Overflow beats syscall
    exe_overflow = 1; id_syscall = 1; exe_pc = 32'h80; id_pc = 32'h88;
    tick();
    clear_events();
    chk("ov_code", {27'b0, cause_out[6:2]}, 32'd12);
    chk("ov_epc", epc_out, 32'h80);
    chk("ov_rpc", bus.redirect_pc, 32'h4);
    tick();
    id_eret = 1;
    tick();
    clear_events();
    tick();
    chk("eret2_status", status_out, 32'h0000_0401);

    // MTC0 EPC suppressed by id_unknown, then reset during TRAP
    bus.redirect_ready = 0;
    bus.mtc0_we = 1; bus.mtc0_addr = 5'd14; bus.mtc0_wdata = 32'hDEAD_BEEF;
    id_unknown = 1; id_pc = 32'h44;
    tick();
    clear_events();
    chk("ri_epc", epc_out, 32'h44);
    chk("ri_code", {27'b0, cause_out[6:2]}, 32'd10);
    tick();
    chk("ri_hold", {31'b0, bus.redirect_valid}, 32'd1);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("rst_mid_flush", {31'b0, bus.flush}, 32'd0);
    chk("rst_mid_status", status_out, 32'h0);
    tick();
    rst_n = 1;

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) irq = 6'($urandom);
      exe_overflow = ($urandom_range(0, 15) == 0);
      id_syscall   = ($urandom_range(0, 15) == 0);
      id_unknown   = ($urandom_range(0, 15) == 0);
      id_eret      = ($urandom_range(0, 11) == 0);
      id_pc        = $urandom & 32'hFFFF_FFFC;
      exe_pc       = $urandom & 32'hFFFF_FFFC;
      bus.mtc0_we  = ($urandom_range(0, 3) == 0);
      bus.mtc0_addr = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 2));
      bus.mtc0_wdata = $urandom;
      bus.mfc0_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 2));
      bus.redirect_ready = $urandom_range(0, 1);
      if ($urandom_range(0, 499) == 0) rst_n = 0;
      else rst_n = 1;
      tick();
    end
    clear_events();
    rst_n = 1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_exception_unit.md
# cp0_exception_unit

Coprocessor-0 consumer side of the STATUS/CAUSE/EPC protocol for the pipelined MIPS core. It reads STATUS (IE, EXL, IM) together with pending interrupt and exception requests, decides when a trap or ERET is taken, and updates STATUS, CAUSE and EPC. It then drives a flush and a PC-redirect handshake to fetch. It sits beside the ID/EXE stages and owns the CP0 registers read by MFC0 and written by MTC0.

## Interface
- EXC_VECTOR, 32'h0000_0004, trap handler entry PC
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- irq  in  6  external interrupt levels, map to CAUSE.IP[7:2]
- id_syscall  in  1  SYSCALL in ID
- id_unknown  in  1  reserved or unknown opcode in ID
- id_eret  in  1  ERET in ID
- exe_overflow  in  1  arithmetic overflow in EXE
- id_pc  in  32  PC of ID instruction
- exe_pc  in  32  PC of EXE instruction
- mtc0_we  in  1  MTC0 write strobe
- mtc0_addr  in  5  CP0 register number (12 STATUS, 13 CAUSE, 14 EPC)
- mtc0_wdata  in  32  write data
- mfc0_addr  in  5  read register number
- mfc0_rdata  out  32  combinational read data; unmapped numbers read 0
- redirect_ready  in  1  fetch accepts redirect this cycle
- redirect_valid  out  1  redirect request
- redirect_pc  out  32  target PC, stable while redirect_valid=1
- flush  out  1  kill IF/ID/EXE contents; equals redirect_valid
- status_out, cause_out, epc_out  out  32 each  current register values

## Operation
- STATUS fields: [0] IE, [1] EXL, [15:8] IM. All other bits write-ignored and read 0.
- CAUSE fields: [6:2] ExcCode, [15:8] IP.
  - IP[7:2] are reloaded every cycle from the sampled irq.
  - IP[1:0] are software bits, writable only through MTC0.
- EPC is 32-bit. MTC0 writes it in full.
- FSM states: RUN, TRAP, RET.
- Event priority in RUN, highest first:
  1. exe_overflow: ExcCode 12, EPC=exe_pc
  2. id_syscall: ExcCode 8, EPC=id_pc
  3. id_unknown: ExcCode 10, EPC=id_pc
  4. id_eret
  5. Interrupt: condition is IE & ~EXL & |(IP & IM). ExcCode 0, EPC=id_pc.
- Trap (priorities 1, 2, 3, 5):
  - Set EXL and write ExcCode.
  - Write EPC only if EXL was 0 before the trap.
  - Latch redirect_pc=EXC_VECTOR and go to TRAP.
- ERET: clear EXL, latch redirect_pc=EPC, go to RET.
- TRAP and RET:
  - redirect_valid=1 and flush=1.
  - New events are ignored.
  - Move to RUN on the cycle redirect_ready=1.
- MTC0 is applied only in RUN with no event that cycle. An event in the same cycle suppresses the write, because that instruction is flushed.
- Exceptions taken while EXL=1 still redirect and update ExcCode. Interrupts stay masked.

## Timing
- Reset values: STATUS=0, CAUSE=0, EPC=0, state RUN, redirect_valid=0, flush=0, redirect_pc=0.
- Event sampled in cycle N leads to updated registers, redirect_valid=1 and flush=1 from cycle N+1.
- Redirect hold: signals stay high through the cycle with redirect_ready=1 (inclusive) and drop the next cycle. Minimum pulse is 1 cycle.
- MTC0 takes effect at the next edge. MFC0 in the same cycle returns the old value (no bypass).
- irq to IP latency: 2 cycles with synchronizer, 0 cycles without (see Configuration).
- Reset asserted mid-TRAP or mid-RET: immediate return to reset values, and the pending redirect is dropped.

## Configuration
- CP0_IRQ_SYNC_EN defined:
  - irq passes through a two-flop synchronizer before CAUSE.IP[7:2].
  - irq-to-trap latency is 3 cycles (2 sync, 1 register).
- Undefined:
  - irq is treated as synchronous to clk and loads IP directly.
  - irq-to-trap latency is 1 cycle.

## Test plan
- Reset, then check all outputs 0. MFC0 of regs 12, 13, 14 and 5 all read 0.
- MTC0 STATUS=32'h0000_0401 (IE=1, IM[2]=1), irq[0]=1, id_pc=32'h40 -> redirect_pc=32'h4, EPC=32'h40, ExcCode=0, STATUS=32'h0000_0403. Also check flush length with redirect_ready held low 3 cycles.
- exe_overflow=1, id_syscall=1, exe_pc=32'h80 in the same cycle -> ExcCode=12, EPC=32'h80, syscall ignored.
- With EXL=1 and EPC=32'h40, assert id_syscall with id_pc=32'h90 -> ExcCode=8, EPC stays 32'h40. A pending interrupt is not taken.
- id_eret with EPC=32'h40 -> redirect_pc=32'h40, EXL cleared, RET lasts exactly 1 cycle when redirect_ready=1.
- mtc0_we to EPC in the same cycle as id_unknown -> write suppressed, EPC=id_pc. Then deassert rst_n during TRAP -> redirect_valid=0 immediately.
